// File: rtl/k4n8_cfg_loader.sv
// Serial configuration loader for a K4/N8 cluster: shifts in a 144-bit frame,
// verifies an XOR-byte checksum and commits LUT masks and flop INIT bits atomically.
module k4n8_cfg_loader #(
  parameter int NUM_LUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  output logic [16*NUM_LUT-1:0]  lut_cfg,
  output logic [NUM_LUT-1:0]     ff_init,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int         LUT_W      = 16 * NUM_LUT;
  localparam int         DATA_W     = LUT_W + NUM_LUT;
  localparam logic [7:0] DATA_BITS  = 8'(DATA_W);
  localparam logic [7:0] FRAME_LAST = 8'(DATA_W + 7);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

  state_t              state, state_nxt;
  logic [7:0]          cnt;
  logic [DATA_W-1:0]   shadow;
  logic [7:0]          rx_sum;
  logic [7:0]          calc_sum;
  logic [2:0]          sum_idx;
  logic                accept;
  logic                sum_ok;
  logic                restart;

  assign accept  = bit_valid && bit_ready;
  assign sum_idx = 3'(cnt - DATA_BITS);
  assign sum_ok  = (calc_sum == rx_sum);
  assign restart = start && (state == IDLE || state == DONE || state == ERR);

  always_comb begin
    calc_sum = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      calc_sum = calc_sum ^ shadow[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bit_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
        if (accept && cnt == FRAME_LAST) state_nxt = CHECK;
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = sum_ok ? DONE : ERR;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = LOAD;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data bits land in the shadow; the trailing 8 bits are the received checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      shadow  <= '0;
      rx_sum  <= '0;
      lut_cfg <= '0;
      ff_init <= '0;
    end else begin
      if (restart) begin
        cnt <= '0;
      end else if (accept) begin
        if (cnt < DATA_BITS) begin
          shadow[cnt] <= bit_in;
        end else begin
          rx_sum[sum_idx] <= bit_in;
        end
        cnt <= cnt + 8'd1;
      end
      if (state == CHECK && sum_ok) begin
        lut_cfg <= shadow[LUT_W-1:0];
        ff_init <= shadow[DATA_W-1:LUT_W];
      end
    end
  end

endmodule
